uart_fifo_ctrl: RTL and testbench

- Next-generation RS-232 peripheral that replaces the fixed-rate rs232in/rs232out/rs232 trio.
- Adds parametrised TX and RX FIFOs, a runtime-programmable baud divisor, sticky error flags and hardware CTS/RTS flow control.
- Sits behind peri_ctrl as a register-mapped target and drives ser_txd/ser_nrts directly.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_fifo_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART peripheral.
// Contents: register addresses, STATUS bit positions, serial frame state
// encoding, the minimum legal bit period and its clamp helper.
package uart_pkg;

    // Register map (addr input).
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    // STATUS register bit positions.
    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_OVR       = 4;
    localparam int ST_FERR      = 5;
    localparam int ST_TXOVF     = 6;
    localparam int ST_TX_ACTIVE = 7;
    localparam int ST_CTS       = 8;

    // Shortest bit period the receiver can still centre-sample reliably.
    localparam logic [15:0] MIN_DIV = 16'd4;

    // Serial frame position, shared by the TX and RX engines.
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_START = 2'd1,
        FS_DATA  = 2'd2,
        FS_STOP  = 2'd3
    } frame_state_t;

    // Bit periods below MIN_DIV are raised to MIN_DIV.
    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output.
// Ports: clk, rst_n (async, active low); push/din write a word when not full;
//        pop advances when not empty; dout shows the oldest word;
//        full, empty and count (0..2**AW) report the fill level.
module sync_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // count never exceeds DEPTH, so its top bit alone marks "full".
    assign full      = count_r[AW];
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// Register-mapped 8N1 UART with TX/RX FIFOs, programmable bit period,
// sticky error flags and CTS/RTS hardware flow control.
// Ports: clk, rst_n (async, active low);
//        addr/rd/wr/wdata -> rdata/rd_valid : register bus, read data one cycle after rd;
//        ser_rxd, ser_ncts : asynchronous serial inputs (synchronised here);
//        ser_txd, ser_nrts : serial outputs; irq : RX data pending or error flag set.
module uart_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int FREQ      = 40_000_000,
    parameter int BPS       = 115_200,
    parameter int TX_AW     = 4,
    parameter int RX_AW     = 4,
    parameter int RTS_SLACK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_valid,
    input  logic        ser_rxd,
    input  logic        ser_ncts,
    output logic        ser_txd,
    output logic        ser_nrts,
    output logic        irq
);

    localparam logic [15:0]    RESET_DIV = 16'(FREQ / BPS);
    localparam logic [RX_AW:0] RX_DEPTH  = (RX_AW+1)'(1 << RX_AW);
    localparam logic [RX_AW:0] RTS_LIMIT = (RX_AW+1)'(RTS_SLACK);

    // Synchronisers and edge history.
    logic rxd_meta_r, rxd_sync_r, rxd_prev_r, ncts_meta_r, ncts_sync_r, cts_s;

    // Bus decode.
    logic wr_data_s, wr_status_s, wr_div_s, rd_data_s;

    // FIFO interfaces.
    logic             tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [7:0]       tx_dout_s;
    logic [TX_AW:0]   tx_count_s;
    logic             rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
    logic [7:0]       rx_dout_s;
    logic [RX_AW:0]   rx_count_s;
    logic [RX_AW:0]   rx_free_s;

    // Control registers and flags.
    logic [15:0] div_r;
    logic        ovr_r, ferr_r, txovf_r;
    logic        ovr_set_s, ferr_set_s, txovf_set_s;
    logic [31:0] rdata_r, rd_mux_s;
    logic        rd_valid_r, irq_r, nrts_r;
    logic [8:0]  status_s;

    // TX engine.
    frame_state_t tx_state_r, tx_state_s;
    logic [15:0]  tx_cnt_r, tx_cnt_s, tx_div_r, tx_div_s;
    logic [2:0]   tx_bit_r, tx_bit_s;
    logic [7:0]   tx_shift_r, tx_shift_s;
    logic         txd_r, txd_s, tx_bit_end_s, tx_active_s;

    // RX engine.
    frame_state_t rx_state_r, rx_state_s;
    logic [15:0]  rx_cnt_r, rx_cnt_s, rx_div_r, rx_div_s;
    logic [2:0]   rx_bit_r, rx_bit_s;
    logic [7:0]   rx_shift_r, rx_shift_s;
    logic         rx_bit_end_s, rx_half_end_s;

    logic unused_s;
    assign unused_s = ^wdata[31:16];

    assign wr_data_s   = wr && (addr == REG_DATA);
    assign wr_status_s = wr && (addr == REG_STATUS);
    assign wr_div_s    = wr && (addr == REG_DIV);
    assign rd_data_s   = rd && (addr == REG_DATA);
    assign tx_push_s   = wr_data_s && !tx_full_s;
    assign txovf_set_s = wr_data_s && tx_full_s;
    assign rx_pop_s    = rd_data_s && !rx_empty_s;
    assign cts_s       = ~ncts_sync_r;
    assign rx_free_s   = RX_DEPTH - rx_count_s;
    assign tx_active_s = (tx_state_r != FS_IDLE);

    sync_fifo #(.AW(TX_AW), .W(8)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push_s), .din(wdata[7:0]), .pop(tx_pop_s),
        .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
    );

    sync_fifo #(.AW(RX_AW), .W(8)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push_s), .din(rx_shift_r), .pop(rx_pop_s),
        .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
    );

    // Two-flop synchronisers; rxd_prev_r keeps one more sample for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {rxd_meta_r, rxd_sync_r, rxd_prev_r, ncts_meta_r, ncts_sync_r} <= 5'b11111;
        end else begin
            rxd_meta_r  <= ser_rxd;
            rxd_sync_r  <= rxd_meta_r;
            rxd_prev_r  <= rxd_sync_r;
            ncts_meta_r <= ser_ncts;
            ncts_sync_r <= ncts_meta_r;
        end
    end

    // Each engine latches its own copy of DIV at frame start, so DIV writes
    // never disturb a frame in flight.
    assign tx_bit_end_s  = (tx_cnt_r == tx_div_r - 16'd1);
    assign rx_bit_end_s  = (rx_cnt_r == rx_div_r - 16'd1);
    assign rx_half_end_s = (rx_cnt_r == {1'b0, rx_div_r[15:1]} - 16'd1);

    // TX next-state: CTS only gates the IDLE->START decision.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_div_s   = tx_div_r;
        txd_s      = txd_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            FS_IDLE: begin
                txd_s = 1'b1;
                if (!tx_empty_s && cts_s) begin
                    tx_state_s = FS_START;
                    tx_pop_s   = 1'b1;
                    tx_shift_s = tx_dout_s;
                    tx_div_s   = div_r;
                    tx_cnt_s   = 16'd0;
                    txd_s      = 1'b0;
                end else begin
                    tx_cnt_s = 16'd0;
                end
            end
            FS_START: begin
                if (tx_bit_end_s) begin
                    tx_state_s = FS_DATA;
                    tx_cnt_s   = 16'd0;
                    tx_bit_s   = 3'd0;
                    txd_s      = tx_shift_r[0];
                    tx_shift_s = {1'b0, tx_shift_r[7:1]};
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            FS_DATA: begin
                if (tx_bit_end_s) begin
                    tx_cnt_s = 16'd0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = FS_STOP;
                        txd_s      = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        txd_s      = tx_shift_r[0];
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            FS_STOP: begin
                if (tx_bit_end_s) begin
                    tx_state_s = FS_IDLE;
                    tx_cnt_s   = 16'd0;
                end else begin
                    tx_cnt_s = tx_cnt_r + 16'd1;
                end
            end
            default: begin
                tx_state_s = FS_IDLE;
                txd_s      = 1'b1;
            end
        endcase
    end

    // TX state register; ser_txd comes straight from txd_r so reset idles the line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_r <= FS_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_div_r   <= RESET_DIV;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_div_r   <= tx_div_s;
            txd_r      <= txd_s;
        end
    end

    // RX next-state: half-period check rejects glitches, then samples bit centres.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_div_s   = rx_div_r;
        rx_push_s  = 1'b0;
        ovr_set_s  = 1'b0;
        ferr_set_s = 1'b0;
        case (rx_state_r)
            FS_IDLE: begin
                if (rxd_prev_r && !rxd_sync_r) begin
                    rx_state_s = FS_START;
                    rx_cnt_s   = 16'd0;
                    rx_div_s   = div_r;
                end else begin
                    rx_cnt_s = 16'd0;
                end
            end
            FS_START: begin
                if (rx_half_end_s) begin
                    rx_cnt_s = 16'd0;
                    rx_bit_s = 3'd0;
                    if (rxd_sync_r) begin
                        rx_state_s = FS_IDLE;
                    end else begin
                        rx_state_s = FS_DATA;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            FS_DATA: begin
                if (rx_bit_end_s) begin
                    rx_cnt_s   = 16'd0;
                    rx_shift_s = {rxd_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = FS_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            FS_STOP: begin
                if (rx_bit_end_s) begin
                    rx_state_s = FS_IDLE;
                    rx_cnt_s   = 16'd0;
                    if (!rxd_sync_r) begin
                        ferr_set_s = 1'b1;
                    end else if (rx_full_s) begin
                        ovr_set_s = 1'b1;
                    end else begin
                        rx_push_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 16'd1;
                end
            end
            default: begin
                rx_state_s = FS_IDLE;
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_r <= FS_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_div_r   <= RESET_DIV;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_div_r   <= rx_div_s;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s               = 9'd0;
        status_s[ST_TX_FULL]   = tx_full_s;
        status_s[ST_TX_EMPTY]  = tx_empty_s;
        status_s[ST_RX_EMPTY]  = rx_empty_s;
        status_s[ST_RX_FULL]   = rx_full_s;
        status_s[ST_OVR]       = ovr_r;
        status_s[ST_FERR]      = ferr_r;
        status_s[ST_TXOVF]     = txovf_r;
        status_s[ST_TX_ACTIVE] = tx_active_s;
        status_s[ST_CTS]       = cts_s;
    end

    // Read data multiplexer.
    always_comb begin
        rd_mux_s = 32'd0;
        case (addr)
            REG_DATA: begin
                if (!rx_empty_s) begin
                    rd_mux_s = {23'd0, 1'b1, rx_dout_s};
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
            REG_STATUS: rd_mux_s = {23'd0, status_s};
            REG_DIV:    rd_mux_s = {16'd0, div_r};
            REG_COUNT:  rd_mux_s = {8'd0, 8'(rx_count_s), 8'd0, 8'(tx_count_s)};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Divisor, sticky flags (a same-cycle set wins over write-1-to-clear) and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r      <= RESET_DIV;
            ovr_r      <= 1'b0;
            ferr_r     <= 1'b0;
            txovf_r    <= 1'b0;
            rdata_r    <= 32'd0;
            rd_valid_r <= 1'b0;
            irq_r      <= 1'b0;
            nrts_r     <= 1'b0;
        end else begin
            if (wr_div_s) begin
                div_r <= clamp_div(wdata[15:0]);
            end
            ovr_r      <= ovr_set_s   | (ovr_r   & ~(wr_status_s & wdata[ST_OVR]));
            ferr_r     <= ferr_set_s  | (ferr_r  & ~(wr_status_s & wdata[ST_FERR]));
            txovf_r    <= txovf_set_s | (txovf_r & ~(wr_status_s & wdata[ST_TXOVF]));
            rdata_r    <= rd ? rd_mux_s : 32'd0;
            rd_valid_r <= rd;
            irq_r      <= ~rx_empty_s | ovr_r | ferr_r | txovf_r;
            nrts_r     <= (rx_free_s <= RTS_LIMIT);
        end
    end

    assign rdata    = rdata_r;
    assign rd_valid = rd_valid_r;
    assign ser_txd  = txd_r;
    assign ser_nrts = nrts_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Self-checking bench for uart_fifo_ctrl: register-read vector table plus
// hand-written serial sequences; read results are checked through a queue.
module tb_uart_fifo_ctrl;
    import uart_pkg::*;

    localparam int TB_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n, rd, wr, ser_rxd, ser_ncts;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        rd_valid, ser_txd, ser_nrts, irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        do_wr;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [31:0] mask;
    } vec_t;
    vec_t vecs[10];

    logic rd_seen = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(
        .FREQ(40_000_000), .BPS(115_200), .TX_AW(4), .RX_AW(4), .RTS_SLACK(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .wdata(wdata),
        .rdata(rdata), .rd_valid(rd_valid), .ser_rxd(ser_rxd), .ser_ncts(ser_ncts),
        .ser_txd(ser_txd), .ser_nrts(ser_nrts), .irq(irq)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // What the DUT saw on rd at each edge; rd_valid must echo it one cycle later.
    always @(posedge clk) rd_seen <= rd;

    // Scoreboard: pop one expectation per rd_valid pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (rd_seen === 1'b1 || rd_valid === 1'b1)) begin
            check32("rd_valid", {31'd0, rd_valid}, {31'd0, rd_seen});
            if (rd_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check32("sb_underflow", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.mask != 32'd0) begin
                        check32(e.name, rdata & e.mask, e.exp & e.mask);
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic chk_read(input logic [1:0] a, input logic [31:0] e,
                            input logic [31:0] m, input string nm);
        @(negedge clk);
        addr = a; rd = 1'b1;
        sb_q.push_back('{exp: e, mask: m, name: nm});
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            ser_rxd = bits[k];
            repeat (TB_DIV) @(negedge clk);
        end
        ser_rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_txd_low(input int bound, input string nm);
        int n;
        n = 0;
        while (ser_txd !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check32(nm, {31'd0, ser_txd}, 32'd0);
    endtask

    function automatic logic exp_txd(input int i, input logic [7:0] b);
        if (i < TB_DIV) return 1'b0;
        else if (i < 9 * TB_DIV) return b[(i - TB_DIV) / TB_DIV];
        else return 1'b1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, REG_DATA,   32'd0,          32'h0000_0000, 32'hFFFF_FFFF};
        vecs[1] = '{1'b0, REG_STATUS, 32'd0,          32'h0000_0106, 32'hFFFF_FFFF};
        vecs[2] = '{1'b0, REG_DIV,    32'd0,          32'h0000_015B, 32'hFFFF_FFFF};
        vecs[3] = '{1'b0, REG_COUNT,  32'd0,          32'h0000_0000, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, REG_DIV,    32'd2,          32'h0000_0004, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, REG_DIV,    32'd0,          32'h0000_0004, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, REG_DIV,    32'h0001_2345,  32'h0000_2345, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, REG_DIV,    32'd5,          32'h0000_0005, 32'hFFFF_FFFF};
        vecs[8] = '{1'b1, REG_DIV,    32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFF_FFFF};
        vecs[9] = '{1'b1, REG_DIV,    32'd8,          32'h0000_0008, 32'hFFFF_FFFF};

        rd = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 32'd0;
        ser_rxd = 1'b1; ser_ncts = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check32("rst_txd",      {31'd0, ser_txd},  32'd1);
        check32("rst_nrts",     {31'd0, ser_nrts}, 32'd0);
        check32("rst_irq",      {31'd0, irq},      32'd0);
        check32("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check32("rst_rdata",    rdata,             32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset register values and DIV clamping.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].a, vecs[i].wd);
            chk_read(vecs[i].a, vecs[i].exp, vecs[i].mask, $sformatf("vec%0d", i));
        end

        // TX frame 0x55 at DIV=8, with tx_active read on the last STOP cycle and the one after.
        bus_write(REG_DATA, 32'h55);
        wait_txd_low(20, "tx_start_timeout");
        for (int i = 0; i < 82; i++) begin
            check32($sformatf("tx_bit%0d", i), {31'd0, ser_txd}, {31'd0, exp_txd(i, 8'h55)});
            if (i == 79) begin
                addr = REG_STATUS; rd = 1'b1;
                sb_q.push_back('{exp: 32'h80, mask: 32'h80, name: "tx_active_hi"});
            end else if (i == 80) begin
                sb_q.push_back('{exp: 32'h00, mask: 32'h80, name: "tx_active_lo"});
            end else begin
                rd = 1'b0;
            end
            @(negedge clk);
        end

        // RX frame 0xA3.
        send_frame(8'hA3, 1'b1);
        check32("irq_rx", {31'd0, irq}, 32'd1);
        chk_read(REG_DATA, 32'h1A3, 32'hFFFF_FFFF, "rx_data");
        chk_read(REG_STATUS, 32'h4, 32'h4, "rx_empty_after");
        repeat (2) @(negedge clk);
        check32("irq_clear", {31'd0, irq}, 32'd0);

        // Framing error, then a short glitch.
        send_frame(8'h3C, 1'b0);
        chk_read(REG_STATUS, 32'h20, 32'h30, "ferr_set");
        chk_read(REG_COUNT, 32'h0, 32'h00FF_0000, "ferr_count");
        check32("irq_ferr", {31'd0, irq}, 32'd1);
        bus_write(REG_STATUS, 32'h20);
        chk_read(REG_STATUS, 32'h0, 32'h20, "ferr_clr");
        repeat (2) @(negedge clk);
        check32("irq_ferr_clr", {31'd0, irq}, 32'd0);
        @(negedge clk);
        ser_rxd = 1'b0;
        repeat (2) @(negedge clk);
        ser_rxd = 1'b1;
        repeat (100) @(negedge clk);
        chk_read(REG_COUNT, 32'h0, 32'h00FF_0000, "glitch_count");
        chk_read(REG_STATUS, 32'h4, 32'h34, "glitch_status");

        // TX overflow with CTS withheld.
        ser_ncts = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 17; k++) bus_write(REG_DATA, 32'(k));
        chk_read(REG_STATUS, 32'h41, 32'h43, "txovf_full");
        chk_read(REG_COUNT, 32'h10, 32'hFF, "tx_count16");
        begin
            int lows;
            lows = 0;
            repeat (40) begin
                @(negedge clk);
                if (ser_txd !== 1'b1) lows++;
            end
            check32("txd_held_no_cts", 32'(lows), 32'd0);
        end
        check32("irq_txovf", {31'd0, irq}, 32'd1);
        bus_write(REG_STATUS, 32'h40);
        chk_read(REG_STATUS, 32'h0, 32'h40, "txovf_clr");

        // Reset in the middle of a TX frame (first byte is 0x00, so the line is low).
        ser_ncts = 1'b0;
        wait_txd_low(20, "tx_cts_start_timeout");
        repeat (20) @(negedge clk);
        check32("tx_mid_frame", {31'd0, ser_txd}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check32("txd_on_reset", {31'd0, ser_txd}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_read(REG_STATUS, 32'h106, 32'h1FF, "post_reset_status");
        chk_read(REG_COUNT, 32'h0, 32'hFFFF_FFFF, "post_reset_count");
        chk_read(REG_DIV, 32'd347, 32'hFFFF_FFFF, "post_reset_div");

        // RX fill: RTS threshold, full, overrun, then drain in order.
        bus_write(REG_DIV, 32'(TB_DIV));
        for (int k = 0; k < 16; k++) begin
            send_frame(8'h10 + 8'(k), 1'b1);
            if (k == 10) check32("nrts_after11", {31'd0, ser_nrts}, 32'd0);
            if (k == 11) check32("nrts_after12", {31'd0, ser_nrts}, 32'd1);
        end
        chk_read(REG_STATUS, 32'h08, 32'h18, "rx_full16");
        send_frame(8'hEE, 1'b1);
        chk_read(REG_STATUS, 32'h18, 32'h18, "ovr_set");
        chk_read(REG_COUNT, 32'h0010_0000, 32'h00FF_0000, "rx_count16");
        for (int k = 0; k < 16; k++) begin
            chk_read(REG_DATA, {23'd0, 1'b1, 8'h10 + 8'(k)}, 32'hFFFF_FFFF,
                     $sformatf("rx_drain%0d", k));
        end
        chk_read(REG_DATA, 32'h0, 32'hFFFF_FFFF, "rx_empty_read");
        repeat (3) @(negedge clk);
        check32("nrts_release", {31'd0, ser_nrts}, 32'd0);

        repeat (5) @(negedge clk);
        check32("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
